// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset vector, halt opcode and
// the fetch FSM state encoding used by the fetch unit, ROM and CPU top.
package cpu_pkg;

  localparam int          CPU_WIDTH      = 8;
  localparam int          CPU_RESET_ADDR = 0;
  localparam logic [7:0]  CPU_HLT_OPCODE = 8'hFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Program-ROM read bus: the fetch unit drives the address and the ROM
// answers combinationally with the opcode and argument stored there.
interface fetch_unit_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] arg;

  modport master (
    output addr,
    input  instr,
    input  arg
  );

  modport slave (
    input  addr,
    output instr,
    output arg
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset to the reset vector, a
// load port for redirects and an increment that wraps modulo 2^WIDTH.
module pc_reg #(
  parameter int WIDTH      = 8,
  parameter int RESET_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);

  // Reset beats load, load beats increment; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= WIDTH'(RESET_ADDR);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the ROM address and
// captures the combinational ROM response into the instruction register.
// A RUN/HALT FSM parks fetching on the halt opcode until jmp or resume.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH      = CPU_WIDTH,
  parameter int               RESET_ADDR = CPU_RESET_ADDR,
  parameter logic [WIDTH-1:0] HLT_OPCODE = WIDTH'(CPU_HLT_OPCODE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic             resume,
  fetch_unit_if.master     rom,
  output logic [WIDTH-1:0] ir_instr,
  output logic [WIDTH-1:0] ir_arg,
  output logic [WIDTH-1:0] ir_pc,
  output logic             ir_valid,
  output logic             halted
);

  fetch_state_t     state, state_next;
  logic             pc_load, pc_inc, ir_load, valid_next;
  logic [WIDTH-1:0] pc;

  pc_reg #(
    .WIDTH      (WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jmp_addr),
    .pc       (pc)
  );

  assign rom.addr = pc;
  assign halted   = (state == HALT);

  // Next-state and control decode; en low leaves every default (hold) in place.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    valid_next = ir_valid;
    if (en) begin
      unique case (state)
        RUN: begin
          if (jmp) begin
            pc_load    = 1'b1;
            valid_next = 1'b0;
          end else if (!stall) begin
            ir_load    = 1'b1;
            valid_next = 1'b1;
            if (rom.instr == HLT_OPCODE) begin
              state_next = HALT;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        HALT: begin
          valid_next = 1'b0;
          if (jmp) begin
            pc_load    = 1'b1;
            state_next = RUN;
          end else if (resume) begin
            pc_inc     = 1'b1;
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // FSM state and instruction register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      ir_instr <= '0;
      ir_arg   <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_next;
      ir_valid <= valid_next;
      if (ir_load) begin
        ir_instr <= rom.instr;
        ir_arg   <= rom.arg;
        ir_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a small program ROM.
module tb_fetch_unit;

  typedef struct {
    logic       rst;
    logic       en;
    logic       stall;
    logic       jmp;
    logic [7:0] jaddr;
    logic       resume;
    logic [7:0] e_addr;
    logic [7:0] e_instr;
    logic [7:0] e_arg;
    logic [7:0] e_pc;
    logic       e_valid;
    logic       e_halted;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       stall = 1'b0;
  logic       jmp = 1'b0;
  logic [7:0] jmp_addr = 8'h00;
  logic       resume = 1'b0;
  logic [7:0] ir_instr, ir_arg, ir_pc;
  logic       ir_valid, halted;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  fetch_unit_if #(.WIDTH(8)) rom_bus ();

  fetch_unit #(.WIDTH(8), .RESET_ADDR(0), .HLT_OPCODE(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .stall    (stall),
    .jmp      (jmp),
    .jmp_addr (jmp_addr),
    .resume   (resume),
    .rom      (rom_bus.master),
    .ir_instr (ir_instr),
    .ir_arg   (ir_arg),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Program ROM model answering combinationally on the current address.
  always_comb begin
    rom_bus.instr = 8'h00;
    rom_bus.arg   = 8'h00;
    case (rom_bus.addr)
      8'd0:   begin rom_bus.instr = 8'h10; rom_bus.arg = 8'h05; end
      8'd1:   begin rom_bus.instr = 8'h11; rom_bus.arg = 8'h07; end
      8'd2:   begin rom_bus.instr = 8'h12; rom_bus.arg = 8'h09; end
      8'd3:   begin rom_bus.instr = 8'hFF; rom_bus.arg = 8'h00; end
      8'd254: begin rom_bus.instr = 8'h20; rom_bus.arg = 8'h01; end
      8'd255: begin rom_bus.instr = 8'h21; rom_bus.arg = 8'h02; end
      default: ;
    endcase
  end

  task automatic addVec(input logic r, input logic e, input logic s, input logic j,
                        input logic [7:0] ja, input logic rs,
                        input logic [7:0] ea, input logic [7:0] ei, input logic [7:0] eg,
                        input logic [7:0] ep, input logic ev, input logic eh);
    vec_t v;
    v.rst = r; v.en = e; v.stall = s; v.jmp = j; v.jaddr = ja; v.resume = rs;
    v.e_addr = ea; v.e_instr = ei; v.e_arg = eg; v.e_pc = ep;
    v.e_valid = ev; v.e_halted = eh;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic s, input logic j,
                               input logic [7:0] ja, input logic rs);
    @(negedge clk);
    rst = r; en = e; stall = s; jmp = j; jmp_addr = ja; resume = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " addr"},     rom_bus.addr, v.e_addr);
    checkOutput({tag, " ir_instr"}, ir_instr,     v.e_instr);
    checkOutput({tag, " ir_arg"},   ir_arg,       v.e_arg);
    checkOutput({tag, " ir_pc"},    ir_pc,        v.e_pc);
    checkOutput({tag, " ir_valid"}, {7'd0, ir_valid}, {7'd0, v.e_valid});
    checkOutput({tag, " halted"},   {7'd0, halted},   {7'd0, v.e_halted});
  endtask

  initial begin
    int cycles;

    //      rst en st jp jaddr  rs   addr   instr  arg    pc     v  h
    addVec(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0); // reset
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h02, 8'h11, 8'h07, 8'h01, 1, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'h12, 8'h09, 8'h02, 1, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 1, 1); // HLT loaded
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 0, 1);
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 0, 1); // stall ignored
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 0, 1);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 0, 1);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 0, 1);
    addVec(0, 1, 1, 0, 8'h00, 1, 8'h04, 8'hFF, 8'h00, 8'h03, 0, 0); // resume
    addVec(0, 1, 0, 1, 8'h01, 0, 8'h01, 8'hFF, 8'h00, 8'h03, 0, 0); // jmp 1
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h01, 8'hFF, 8'h00, 8'h03, 0, 0);
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h01, 8'hFF, 8'h00, 8'h03, 0, 0);
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h01, 8'hFF, 8'h00, 8'h03, 0, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h02, 8'h11, 8'h07, 8'h01, 1, 0); // release
    addVec(0, 1, 0, 1, 8'h00, 0, 8'h00, 8'h11, 8'h07, 8'h01, 0, 0); // jmp 0
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0);
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0); // stall at pc1
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0);
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h02, 8'h11, 8'h07, 8'h01, 1, 0);
    addVec(0, 1, 0, 1, 8'h01, 0, 8'h01, 8'h11, 8'h07, 8'h01, 0, 0);
    addVec(0, 1, 0, 1, 8'hFE, 0, 8'hFE, 8'h11, 8'h07, 8'h01, 0, 0); // jmp 254
    addVec(0, 1, 0, 0, 8'h00, 0, 8'hFF, 8'h20, 8'h01, 8'hFE, 1, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h21, 8'h02, 8'hFF, 1, 0); // wrap
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0);
    addVec(0, 1, 1, 1, 8'hFE, 0, 8'hFE, 8'h10, 8'h05, 8'h00, 0, 0); // jmp over stall
    addVec(0, 1, 0, 0, 8'h00, 0, 8'hFF, 8'h20, 8'h01, 8'hFE, 1, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h21, 8'h02, 8'hFF, 1, 0);
    addVec(0, 0, 0, 1, 8'h80, 1, 8'h00, 8'h21, 8'h02, 8'hFF, 1, 0); // en=0 freeze
    addVec(0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h21, 8'h02, 8'hFF, 1, 0);
    addVec(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0); // rst mid-stall
    addVec(0, 1, 0, 1, 8'h03, 0, 8'h03, 8'h00, 8'h00, 8'h00, 0, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 1, 1);
    addVec(0, 0, 0, 1, 8'h40, 1, 8'h03, 8'hFF, 8'h00, 8'h03, 1, 1); // en=0 in HALT
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 0, 1);
    addVec(0, 1, 0, 1, 8'hFE, 1, 8'hFE, 8'hFF, 8'h00, 8'h03, 0, 0); // jmp beats resume
    addVec(0, 1, 0, 0, 8'h00, 0, 8'hFF, 8'h20, 8'h01, 8'hFE, 1, 0);
    addVec(0, 1, 0, 1, 8'h03, 0, 8'h03, 8'h20, 8'h01, 8'hFE, 0, 0);
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 8'h00, 8'h03, 1, 1);
    addVec(1, 1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0); // rst while halted
    addVec(0, 1, 0, 0, 8'h00, 0, 8'h01, 8'h10, 8'h05, 8'h00, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].jmp,
                    vecs[i].jaddr, vecs[i].resume);
      checkAll($sformatf("v%0d", i), vecs[i]);
    end

    // Straight-line run from reset until halt, bounded by a cycle budget.
    applyStimulus(1, 1, 0, 0, 8'h00, 0);
    cycles = 0;
    while (!halted && cycles < 20) begin
      applyStimulus(0, 1, 0, 0, 8'h00, 0);
      cycles++;
    end
    checkOutput("run cycles to halt", 8'(cycles), 8'd4);
    checkOutput("run halt ir_instr", ir_instr, 8'hFF);
    checkOutput("run halt ir_valid", {7'd0, ir_valid}, 8'd1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 0, 0, 8'h00, 0);
      checkOutput($sformatf("park%0d addr", k), rom_bus.addr, 8'h03);
      checkOutput($sformatf("park%0d ir_valid", k), {7'd0, ir_valid}, 8'd0);
    end
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    checkOutput("resume addr", rom_bus.addr, 8'h04);
    checkOutput("resume halted", {7'd0, halted}, 8'd0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    checkOutput("post-resume ir_pc", ir_pc, 8'h04);
    checkOutput("post-resume ir_valid", {7'd0, ir_valid}, 8'd1);
    checkOutput("post-resume addr", rom_bus.addr, 8'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
